// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the LA64 register file: one holding entry per source,
// up to two round-robin grants per cycle driven onto two registered write ports.
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        i_req_valid,
  output logic [NUM_SRC-1:0]        o_req_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] i_req_waddr,
  input  logic [NUM_SRC*DATA_W-1:0] i_req_wdata,
  output logic                      o_we_1,
  output logic [ADDR_W-1:0]         o_waddr_1,
  output logic [DATA_W-1:0]         o_wdata_1,
  output logic                      o_we_2,
  output logic [ADDR_W-1:0]         o_waddr_2,
  output logic [DATA_W-1:0]         o_wdata_2,
  output logic                      o_idle
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W:0] NUM_SRC_W = (IDX_W+1)'(NUM_SRC);

  logic [NUM_SRC-1:0]             held_q;
  logic [NUM_SRC-1:0][ADDR_W-1:0] addr_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] data_q;
  logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] grant;
  logic               slot1_vld, slot2_vld, scan_stop;
  logic [IDX_W-1:0]   slot1_idx, slot2_idx, last_idx;
  logic [IDX_W:0]     scan_pos, rr_sum;

  logic              we1_q, we1_d, we2_q, we2_d;
  logic [ADDR_W-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;

  // Scan from rr_ptr; a same nonzero address in the second pick ends the scan.
  always_comb begin
    grant     = '0;
    slot1_vld = 1'b0;
    slot2_vld = 1'b0;
    slot1_idx = '0;
    slot2_idx = '0;
    scan_stop = 1'b0;
    scan_pos  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_pos >= NUM_SRC_W) scan_pos = scan_pos - NUM_SRC_W;
      if (!scan_stop && held_q[scan_pos[IDX_W-1:0]]) begin
        if (!slot1_vld) begin
          slot1_vld = 1'b1;
          slot1_idx = scan_pos[IDX_W-1:0];
        end else if (!slot2_vld) begin
          if (addr_q[scan_pos[IDX_W-1:0]] == addr_q[slot1_idx] && addr_q[slot1_idx] != '0) begin
            scan_stop = 1'b1;
          end else begin
            slot2_vld = 1'b1;
            slot2_idx = scan_pos[IDX_W-1:0];
          end
        end
      end
    end
    if (slot1_vld) grant[slot1_idx] = 1'b1;
    if (slot2_vld) grant[slot2_idx] = 1'b1;
  end

  always_comb begin
    last_idx = slot2_vld ? slot2_idx : slot1_idx;
    rr_sum   = {1'b0, last_idx} + (IDX_W+1)'(1);
    if (rr_sum == NUM_SRC_W) rr_sum = '0;
    rr_ptr_d = slot1_vld ? rr_sum[IDX_W-1:0] : rr_ptr_q;

    we1_d    = slot1_vld && (addr_q[slot1_idx] != '0);
    waddr1_d = slot1_vld ? addr_q[slot1_idx] : '0;
    wdata1_d = slot1_vld ? data_q[slot1_idx] : '0;
    we2_d    = slot2_vld && (addr_q[slot2_idx] != '0);
    waddr2_d = slot2_vld ? addr_q[slot2_idx] : '0;
    wdata2_d = slot2_vld ? data_q[slot2_idx] : '0;
  end

  assign o_req_ready = ~held_q | grant;
  assign o_idle      = ~|held_q & ~we1_q & ~we2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
      we1_q    <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
      we2_q    <= 1'b0;
      waddr2_q <= '0;
      wdata2_q <= '0;
    end else begin
      for (int n = 0; n < NUM_SRC; n++) begin
        if (i_req_valid[n] && o_req_ready[n]) begin
          held_q[n] <= 1'b1;
          addr_q[n] <= i_req_waddr[n*ADDR_W +: ADDR_W];
          data_q[n] <= i_req_wdata[n*DATA_W +: DATA_W];
        end else if (grant[n]) begin
          held_q[n] <= 1'b0;
        end
      end
      rr_ptr_q <= rr_ptr_d;
      we1_q    <= we1_d;
      waddr1_q <= waddr1_d;
      wdata1_q <= wdata1_d;
      we2_q    <= we2_d;
      waddr2_q <= waddr2_d;
      wdata2_q <= wdata2_d;
    end
  end

  assign o_we_1    = we1_q;
  assign o_waddr_1 = waddr1_q;
  assign o_wdata_1 = wdata1_q;
  assign o_we_2    = we2_q;
  assign o_waddr_2 = waddr2_q;
  assign o_wdata_2 = wdata2_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req_valid, o_req_ready;
  logic [N*AW-1:0] i_req_waddr;
  logic [N*DW-1:0] i_req_wdata;
  logic            o_we_1, o_we_2, o_idle;
  logic [AW-1:0]   o_waddr_1, o_waddr_2;
  logic [DW-1:0]   o_wdata_1, o_wdata_2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_waddr(i_req_waddr), .i_req_wdata(i_req_wdata),
    .o_we_1(o_we_1), .o_waddr_1(o_waddr_1), .o_wdata_1(o_wdata_1),
    .o_we_2(o_we_2), .o_waddr_2(o_waddr_2), .o_wdata_2(o_wdata_2),
    .o_idle(o_idle)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench 1ns after a rising edge with rst low and no requests.
  task automatic do_reset();
    i_req_valid = '0;
    i_req_waddr = '0;
    i_req_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct packed {
    logic        r;
    logic [3:0]  vld;
    logic [19:0] a;
    logic [63:0] d;
    logic [3:0]  rdy;
    logic        we1;
    logic [4:0]  a1;
    logic [15:0] d1;
    logic        we2;
    logic [4:0]  a2;
    logic [15:0] d2;
    logic        idle;
  } vec_t;

  vec_t tbl[14];

  // Reference model state
  bit              m_held[N];
  logic [AW-1:0]   m_addr[N];
  logic [DW-1:0]   m_data[N];
  int              m_rr;
  int              order[$];
  int              g1, g2, last, cnt[N];
  logic [N-1:0]    e_rdy;
  logic            e_we1, e_we2, e_idle;
  logic [AW-1:0]   e_a1, e_a2;
  logic [DW-1:0]   e_d1, e_d2;
  bit              any_held;

  initial begin
    //          r     vld      addrs {s3,s2,s1,s0}      data {s3,s2,s1,s0}                    rdy      we1  a1    d1        we2  a2    d2        idle
    tbl[0]  = '{1'b1, 4'b0001, {5'd0,5'd0,5'd0,5'd5},  {16'h0,16'h0,16'h0,16'h1111},          4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b1,5'd5, 16'h1111, 1'b0,5'd0, 16'h0,    1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b1};
    tbl[3]  = '{1'b1, 4'b1111, {5'd4,5'd3,5'd2,5'd1},  {16'hA004,16'hA003,16'hA002,16'hA001}, 4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b0011, 1'b1,5'd1, 16'hA001, 1'b1,5'd2, 16'hA002, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b1,5'd3, 16'hA003, 1'b1,5'd4, 16'hA004, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b1};
    tbl[7]  = '{1'b1, 4'b0011, {5'd0,5'd0,5'd7,5'd7},  {16'h0,16'h0,16'hB00B,16'hB00A},       4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1101, 1'b1,5'd7, 16'hB00A, 1'b0,5'd0, 16'h0,    1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b1,5'd7, 16'hB00B, 1'b0,5'd0, 16'h0,    1'b0};
    tbl[10] = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b1};
    tbl[11] = '{1'b1, 4'b1100, {5'd9,5'd0,5'd0,5'd0},  {16'hC033,16'hC022,16'h0,16'h0},       4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b0};
    tbl[12] = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b0,5'd0, 16'hC022, 1'b1,5'd9, 16'hC033, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 20'd0,                  64'h0,                                 4'b1111, 1'b0,5'd0, 16'h0,    1'b0,5'd0, 16'h0,    1'b1};

    do_reset();
    chk("reset we1", o_we_1, 0);
    chk("reset we2", o_we_2, 0);
    chk("reset waddr1", o_waddr_1, 0);
    chk("reset wdata2", o_wdata_2, 0);
    chk("reset idle", o_idle, 1);
    chk("reset ready", o_req_ready, 4'b1111);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].r) do_reset();
      i_req_valid = tbl[i].vld;
      i_req_waddr = tbl[i].a;
      for (int n = 0; n < N; n++) i_req_wdata[n*DW +: DW] = {48'h0, tbl[i].d[n*16 +: 16]};
      #1 chk($sformatf("row%0d ready", i), o_req_ready, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d we1", i), o_we_1, tbl[i].we1);
      chk($sformatf("row%0d waddr1", i), o_waddr_1, tbl[i].a1);
      chk($sformatf("row%0d wdata1", i), o_wdata_1, {48'h0, tbl[i].d1});
      chk($sformatf("row%0d we2", i), o_we_2, tbl[i].we2);
      chk($sformatf("row%0d waddr2", i), o_waddr_2, tbl[i].a2);
      chk($sformatf("row%0d wdata2", i), o_wdata_2, {48'h0, tbl[i].d2});
      chk($sformatf("row%0d idle", i), o_idle, tbl[i].idle);
    end

    // Continuous traffic from all four sources: pairs alternate (0,1),(2,3)
    do_reset();
    for (int n = 0; n < N; n++) cnt[n] = 0;
    i_req_valid = 4'b1111;
    i_req_waddr = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int n = 0; n < N; n++) i_req_wdata[n*DW +: DW] = 64'(n);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        chk("stream first we1", o_we_1, 0);
      end else begin
        chk($sformatf("stream c%0d pair1", c), {o_we_1, o_waddr_1}, {1'b1, (c % 2 == 1) ? 5'd1 : 5'd3});
        chk($sformatf("stream c%0d pair2", c), {o_we_2, o_waddr_2}, {1'b1, (c % 2 == 1) ? 5'd2 : 5'd4});
        if (o_we_1 && o_waddr_1 >= 1 && o_waddr_1 <= 4) cnt[o_waddr_1 - 1]++;
        if (o_we_2 && o_waddr_2 >= 1 && o_waddr_2 <= 4) cnt[o_waddr_2 - 1]++;
      end
    end
    for (int n = 0; n < N; n++) chk($sformatf("stream share src%0d", n), (cnt[n] >= 9 && cnt[n] <= 11), 1);
    i_req_valid = '0;
    repeat (3) @(posedge clk);
    #1 chk("stream drained idle", o_idle, 1);

    // Asynchronous reset with three entries held and writes in flight
    do_reset();
    i_req_valid = 4'b0111;
    i_req_waddr = {5'd0, 5'd12, 5'd11, 5'd10};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 chk("pre-reset we1", {o_we_1, o_waddr_1}, {1'b1, 5'd10});
    #1 rst = 1'b1;
    i_req_valid = '0;
    #1;
    chk("async rst we1", o_we_1, 0);
    chk("async rst we2", o_we_2, 0);
    chk("async rst idle", o_idle, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post-reset ready", o_req_ready, 4'b1111);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 chk($sformatf("post-reset quiet c%0d", c), {o_we_1, o_we_2}, 2'b00);
    end
    i_req_valid = 4'b1010;
    i_req_waddr = {5'd20, 5'd0, 5'd21, 5'd0};
    @(posedge clk);
    #1 i_req_valid = '0;
    @(posedge clk);
    #1;
    chk("post-reset rr port1", {o_we_1, o_waddr_1}, {1'b1, 5'd21});
    chk("post-reset rr port2", {o_we_2, o_waddr_2}, {1'b1, 5'd20});
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < N; n++) m_held[n] = 0;
    m_rr = 0;
    for (int c = 0; c < 400; c++) begin
      i_req_valid = N'($urandom);
      for (int n = 0; n < N; n++) begin
        i_req_waddr[n*AW +: AW] = AW'($urandom_range(0, 7));
        i_req_wdata[n*DW +: DW] = {$urandom, $urandom};
      end
      order = {};
      for (int k = 0; k < N; k++) if (m_held[(m_rr + k) % N]) order.push_back((m_rr + k) % N);
      g1 = -1;
      g2 = -1;
      if (order.size() > 0) g1 = order[0];
      if (order.size() > 1 && !(m_addr[order[1]] == m_addr[g1] && m_addr[g1] != 0)) g2 = order[1];
      for (int n = 0; n < N; n++) e_rdy[n] = !m_held[n] || n == g1 || n == g2;
      e_we1 = (g1 >= 0) && m_addr[g1] != 0;
      e_a1  = (g1 >= 0) ? m_addr[g1] : '0;
      e_d1  = (g1 >= 0) ? m_data[g1] : '0;
      e_we2 = (g2 >= 0) && m_addr[g2] != 0;
      e_a2  = (g2 >= 0) ? m_addr[g2] : '0;
      e_d2  = (g2 >= 0) ? m_data[g2] : '0;
      #1 chk($sformatf("rand c%0d ready", c), o_req_ready, e_rdy);
      if (g1 >= 0) m_held[g1] = 0;
      if (g2 >= 0) m_held[g2] = 0;
      last = (g2 >= 0) ? g2 : g1;
      if (last >= 0) m_rr = (last + 1) % N;
      for (int n = 0; n < N; n++) begin
        if (i_req_valid[n] && e_rdy[n]) begin
          m_held[n] = 1;
          m_addr[n] = i_req_waddr[n*AW +: AW];
          m_data[n] = i_req_wdata[n*DW +: DW];
        end
      end
      any_held = 0;
      for (int n = 0; n < N; n++) any_held |= m_held[n];
      e_idle = !any_held && !e_we1 && !e_we2;
      @(posedge clk);
      #1;
      chk($sformatf("rand c%0d port1", c), {o_we_1, o_waddr_1}, {e_we1, e_a1});
      chk($sformatf("rand c%0d wdata1", c), o_wdata_1, e_d1);
      chk($sformatf("rand c%0d port2", c), {o_we_2, o_waddr_2}, {e_we2, e_a2});
      chk($sformatf("rand c%0d wdata2", c), o_wdata_2, e_d2);
      chk($sformatf("rand c%0d idle", c), o_idle, e_idle);
      chk($sformatf("rand c%0d no dual write", c), (o_we_1 && o_we_2 && o_waddr_1 == o_waddr_2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side front end of the LA64 architectural register file.
- Collects writeback results from up to NUM_SRC execution sources, each on a valid/ready handshake, and buffers one result per source.
- Each cycle it selects up to two results and drives the register file's two write ports (we/waddr/wdata pairs) from registered outputs.
- Selection is round-robin. A same-address conflict in one cycle is resolved by holding back the later pick.

Parameters:
- NUM_SRC, 4, number of writeback sources (2..8).
- ADDR_W, 5, register address width (32 arch regs).
- DATA_W, 64, register data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  NUM_SRC  per-source result valid.
- o_req_ready  out  NUM_SRC  per-source ready; transfer on valid&ready at clk edge.
- i_req_waddr  in  NUM_SRC*ADDR_W  per-source destination register; source n at [n*ADDR_W +: ADDR_W].
- i_req_wdata  in  NUM_SRC*DATA_W  per-source result data; source n at [n*DATA_W +: DATA_W].
- o_we_1  out  1  write enable, port 1.
- o_waddr_1  out  ADDR_W  write address, port 1.
- o_wdata_1  out  DATA_W  write data, port 1.
- o_we_2  out  1  write enable, port 2.
- o_waddr_2  out  ADDR_W  write address, port 2.
- o_wdata_2  out  DATA_W  write data, port 2.
- o_idle  out  1  high when no entry is held and both o_we are 0.

Behaviour:
- Per source n: one holding entry {held[n], addr[n], data[n]}.
- o_req_ready[n] = ~held[n] | grant[n]. No combinational path from i_req_valid to o_req_ready.
- Accept (valid&ready) at edge: entry loads addr/data and held=1. A granted entry may be replaced in the same edge (full throughput, 1 result/cycle/source).
- Grant logic is combinational over held entries. Scan indices rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - First held entry found -> slot 1.
  - Next held entry found -> slot 2, unless both have the same nonzero address. In that case slot 2 stays empty this cycle and the scan stops.
  - Address 0 never conflicts.
- Granted entries clear held at the edge unless refilled.
- Output registers load at the edge:
  - o_we_k = slot k filled AND its addr != 0.
  - o_waddr_k / o_wdata_k = slot k entry, or 0 when the slot is empty.
  - Address-0 entries consume a slot and retire with we=0.
- rr_ptr update: (index of last granted entry + 1) mod NUM_SRC. Unchanged if nothing is granted.
- Latency: request accepted at edge E0 -> o_we asserted after E1 -> register file updated at E2.
- A later result from the same source is never granted before an earlier one (single entry per source). Cross-source ordering is the issue logic's responsibility.
- o_we_1 and o_we_2 are never both 1 with equal o_waddr.
- Reset (asynchronous, any time, including mid-stream): all held=0, rr_ptr=0, o_we_1=o_we_2=0, o_waddr_*=0, o_wdata_*=0, o_idle=1. o_req_ready is all ones once reset deasserts. Entries held at reset are discarded.

Test Plan:
- Single source 0 sends addr 5, data 0x1111 for one cycle -> o_we_1=1, o_waddr_1=5, o_wdata_1=0x1111 two edges later, o_we_2=0; o_idle returns to 1.
- Sources 0..3 all valid in the same cycle with addrs 1,2,3,4 -> first grant cycle: {1,2} on ports 1/2; next cycle: {3,4}. Sources 2,3 see o_req_ready=0 for exactly one cycle.
- Sources 0 and 1 both target addr 7 (data A, B) -> cycle 1: port 1 writes 7=A, port 2 idle. Cycle 2: port 1 writes 7=B. Never both we with addr 7.
- All 4 sources valid continuously for 20 cycles with distinct addrs -> each source granted 10 times ±1. Grant pairs rotate (0,1),(2,3),(0,1)...
- Source 2 sends addr 0 alongside source 3 addr 9 -> source 2 retired with o_we_1=0; port 2 carries addr 9 with o_we_2=1.
- Assert rst asynchronously while 3 entries are held -> o_we_* drop to 0 immediately. No writes appear after rst release. First post-reset request is granted from rr_ptr=0.
